// File: rtl/dac_update_sequencer.sv
// -----------------------------------------------------------------------------
// dac_update_sequencer
//
// Purpose:
//   Holds one shadow DAC code per channel and remembers which channels changed.
//   Each changed channel is sent as one 16-bit command word
//   {1'b0, channel, code} to the fifo2shiftreg serializer FIFO. Channels are
//   served round-robin, starting after the last channel sent. The block waits
//   while the FIFO reports FULL.
//
// Ports:
//   CLK         system clock; also the serializer FIFO write clock
//   RESET       synchronous, active-high reset
//   CFG_WE      write strobe: store CFG_DATA into channel CFG_ADDR and mark it dirty
//   CFG_ADDR    channel index for CFG_WE
//   CFG_DATA    new DAC code for CFG_WE
//   UPDATE_ALL  one-cycle pulse that marks every channel dirty
//   FIFO_FULL   serializer FIFO FULL
//   FIFO_DIN    command word to the serializer FIFO
//   FIFO_WR_EN  FIFO write enable; one word is written per high cycle
//   BUSY        high while the sequencer is not idle
//   DONE        one-cycle pulse when the dirty set has drained
//
// Configuration:
//   DAC_SEQ_LDAC_EN  When this is defined, a batch that pushed at least one
//                    word ends with the load-DAC word 16'h8000. DONE then
//                    pulses after that word has been accepted.
// -----------------------------------------------------------------------------
module dac_update_sequencer #(
    parameter int NCH      = 8,
    parameter int CH_BITS  = 3,
    parameter int VAL_BITS = 12
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                CFG_WE,
    input  logic [CH_BITS-1:0]  CFG_ADDR,
    input  logic [VAL_BITS-1:0] CFG_DATA,
    input  logic                UPDATE_ALL,
    input  logic                FIFO_FULL,
    output logic [15:0]         FIFO_DIN,
    output logic                FIFO_WR_EN,
    output logic                BUSY,
    output logic                DONE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_PUSH = 2'd2
`ifdef DAC_SEQ_LDAC_EN
        , ST_LDAC = 2'd3
`endif
    } state_t;

    localparam logic [15:0] LDAC_WORD = 16'h8000;

    state_t              state;
    logic [VAL_BITS-1:0] val [NCH];
    logic [NCH-1:0]      dirty;
    logic [NCH-1:0]      dirty_nxt;
    logic [CH_BITS-1:0]  ptr;
    logic [CH_BITS-1:0]  ch_q;
    logic [15:0]         word_q;

    logic [CH_BITS-1:0]  cand;
    logic [CH_BITS-1:0]  arb_ch;
    logic                arb_hit;
    logic [15:0]         arb_word;
    logic                push_state;

`ifdef DAC_SEQ_LDAC_EN
    logic                pushed_q;   // at least one channel word was pushed in this batch
`endif

    // Round-robin search. The search starts at ptr. Index arithmetic is
    // CH_BITS wide, so it wraps modulo NCH.
    // NOTE: every signal driven in always_comb gets a default first. Without
    // one, a path that skips the assignment infers a latch.
    always_comb begin
        arb_hit = 1'b0;
        arb_ch  = ptr;
        cand    = ptr;
        for (int i = 0; i < NCH; i++) begin
            cand = ptr + CH_BITS'(i);
            if (!arb_hit && dirty[cand]) begin
                arb_hit = 1'b1;
                arb_ch  = cand;
            end
        end
    end

    // Command word: the channel sits directly above the code, with zero
    // padding up to bit 14. Bit 15 stays clear for channel words.
    assign arb_word = {1'b0, (15'(arb_ch) << VAL_BITS) | 15'(val[arb_ch])};

    // Next dirty set. Assignments later in this block win. So if CFG_WE hits
    // the channel that ARB is clearing in the same cycle, the bit stays set
    // and that channel is sent again with its new code.
    always_comb begin
        dirty_nxt = dirty;
        if (state == ST_ARB && arb_hit) begin
            dirty_nxt[arb_ch] = 1'b0;
        end
        if (UPDATE_ALL) begin
            dirty_nxt = '1;
        end
        if (CFG_WE) begin
            dirty_nxt[CFG_ADDR] = 1'b1;
        end
    end

    always_comb begin
        push_state = (state == ST_PUSH);
`ifdef DAC_SEQ_LDAC_EN
        push_state = push_state | (state == ST_LDAC);
`endif
    end

    // The write enable is combinational on FULL. This means a word is never
    // offered in a cycle where the FIFO reports full.
    assign FIFO_WR_EN = push_state & ~FIFO_FULL;
    assign FIFO_DIN   = word_q;

    // NOTE: all state in this block uses non-blocking assignments. Every
    // register then updates from the values present before the clock edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= ST_IDLE;
            dirty  <= '0;
            ptr    <= '0;
            ch_q   <= '0;
            word_q <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            // NOTE: the shadow codes are cleared on reset. This is why they
            // are built from flops and not from an inferred RAM, which has no
            // reset.
            for (int i = 0; i < NCH; i++) begin
                val[i] <= '0;
            end
`ifdef DAC_SEQ_LDAC_EN
            pushed_q <= 1'b0;
`endif
        end else begin
            dirty <= dirty_nxt;
            DONE  <= 1'b0;

            if (CFG_WE) begin
                val[CFG_ADDR] <= CFG_DATA;
            end

            case (state)
                ST_IDLE: begin
                    if (|dirty) begin
                        state <= ST_ARB;
                        BUSY  <= 1'b1;
                    end
                end

                ST_ARB: begin
                    if (arb_hit) begin
                        // The latched word keeps the code as it was at this
                        // edge. A write to the same channel in this cycle
                        // goes out in a later word.
                        word_q <= arb_word;
                        ch_q   <= arb_ch;
                        state  <= ST_PUSH;
                    end else begin
`ifdef DAC_SEQ_LDAC_EN
                        if (pushed_q) begin
                            word_q <= LDAC_WORD;
                            state  <= ST_LDAC;
                        end else begin
                            state <= ST_IDLE;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                        end
`else
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
`endif
                    end
                end

                ST_PUSH: begin
                    if (!FIFO_FULL) begin
                        // The word was written this cycle. The next search
                        // starts just after the channel that was sent.
                        ptr   <= ch_q + CH_BITS'(1);
                        state <= ST_ARB;
`ifdef DAC_SEQ_LDAC_EN
                        pushed_q <= 1'b1;
`endif
                    end
                end

`ifdef DAC_SEQ_LDAC_EN
                ST_LDAC: begin
                    if (!FIFO_FULL) begin
                        state    <= ST_IDLE;
                        BUSY     <= 1'b0;
                        DONE     <= 1'b1;
                        pushed_q <= 1'b0;
                    end
                end
`endif

                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_update_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dac_update_sequencer
//
// Directed testbench for dac_update_sequencer in its default build
// (DAC_SEQ_LDAC_EN undefined).
// - Inputs change 1 time unit after each rising edge.
// - Outputs are sampled on the falling edge.
// - A monitor logs every FIFO write and every DONE pulse, each with the cycle
//   number of the rising edge that began that cycle.
// -----------------------------------------------------------------------------
module tb_dac_update_sequencer;

    logic        CLK;
    logic        RESET;
    logic        CFG_WE;
    logic [2:0]  CFG_ADDR;
    logic [11:0] CFG_DATA;
    logic        UPDATE_ALL;
    logic        FIFO_FULL;
    logic [15:0] FIFO_DIN;
    logic        FIFO_WR_EN;
    logic        BUSY;
    logic        DONE;

    dac_update_sequencer #(
        .NCH      (8),
        .CH_BITS  (3),
        .VAL_BITS (12)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .CFG_WE     (CFG_WE),
        .CFG_ADDR   (CFG_ADDR),
        .CFG_DATA   (CFG_DATA),
        .UPDATE_ALL (UPDATE_ALL),
        .FIFO_FULL  (FIFO_FULL),
        .FIFO_DIN   (FIFO_DIN),
        .FIFO_WR_EN (FIFO_WR_EN),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } wr_t;

    int  total;
    int  bad;
    int  cyc_cnt;
    int  t_ref;
    int  full_viol;
    wr_t wlog[$];
    int  dlog[$];

    initial cyc_cnt = 0;
    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    always @(negedge CLK) begin
        if (FIFO_WR_EN === 1'b1) wlog.push_back('{FIFO_DIN, cyc_cnt});
        if (DONE === 1'b1)       dlog.push_back(cyc_cnt);
        if (FIFO_WR_EN === 1'b1 && FIFO_FULL === 1'b1) full_viol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        wlog.delete();
        dlog.delete();
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RESET = 1'b1; CFG_WE = 1'b0; UPDATE_ALL = 1'b0; FIFO_FULL = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
    endtask

    // The write is sampled at edge t_ref. The task returns inside cycle t_ref.
    task automatic drive_cfg(input logic [2:0] ch, input logic [11:0] d);
        @(posedge CLK); #1;
        CFG_WE = 1'b1; CFG_ADDR = ch; CFG_DATA = d;
        @(posedge CLK); #1;
        CFG_WE = 1'b0;
        t_ref = cyc_cnt;
    endtask

    task automatic pulse_update();
        @(posedge CLK); #1;
        UPDATE_ALL = 1'b1;
        @(posedge CLK); #1;
        UPDATE_ALL = 1'b0;
        t_ref = cyc_cnt;
    endtask

    // Wait for BUSY to rise (if it has not already) and then fall, then let a
    // few idle cycles pass. Both waits are bounded.
    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!BUSY && k < 20);
        while (BUSY && k < 300) begin
            @(negedge CLK);
            k++;
        end
        check(tag, {31'd0, BUSY}, 32'd0);
        repeat (4) @(negedge CLK);
    endtask

    initial begin
        int lows, wr_hi, din_bad;
        total = 0; bad = 0; full_viol = 0;
        RESET = 1'b1; CFG_WE = 1'b0; CFG_ADDR = '0; CFG_DATA = '0;
        UPDATE_ALL = 1'b0; FIFO_FULL = 1'b0;

        // Output values during reset and right after it.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_din",   {16'd0, FIFO_DIN}, 32'h0);
        check("rst_wr_en", {31'd0, FIFO_WR_EN}, 32'd0);
        check("rst_busy",  {31'd0, BUSY}, 32'd0);
        check("rst_done",  {31'd0, DONE}, 32'd0);
        @(posedge CLK); #1 RESET = 1'b0;
        @(negedge CLK);
        check("post_rst_busy", {31'd0, BUSY}, 32'd0);

        // Single write: ch5 = ABC. The word is written 2 cycles after the
        // sampling edge, and DONE pulses 2 cycles after that.
        clear_logs();
        drive_cfg(3'd5, 12'hABC);
        @(negedge CLK);
        check("sw_idle_busy", {31'd0, BUSY}, 32'd0);
        @(negedge CLK);
        check("sw_arb_busy",  {31'd0, BUSY}, 32'd1);
        check("sw_arb_wr",    {31'd0, FIFO_WR_EN}, 32'd0);
        @(negedge CLK);
        check("sw_push_wr",   {31'd0, FIFO_WR_EN}, 32'd1);
        check("sw_push_din",  {16'd0, FIFO_DIN}, 32'h5ABC);
        wait_idle("sw_idle_timeout");
        check("sw_count",      wlog.size(), 32'd1);
        check("sw_cycle",      wlog[0].cyc, t_ref + 2);
        check("sw_done_count", dlog.size(), 32'd1);
        check("sw_done_cycle", dlog[0], t_ref + 4);

        // UPDATE_ALL after reset: words 0000 .. 7000, 2 cycles apart.
        do_reset();
        clear_logs();
        pulse_update();
        @(negedge CLK);
        lows = 0;
        for (int i = 0; i < 17; i++) begin
            @(negedge CLK);
            if (!BUSY) lows++;
        end
        check("ua_busy_gaps", lows, 32'd0);
        @(negedge CLK);
        check("ua_end_busy", {31'd0, BUSY}, 32'd0);
        check("ua_end_done", {31'd0, DONE}, 32'd1);
        repeat (3) @(negedge CLK);
        check("ua_count", wlog.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ua_word%0d", i), {16'd0, wlog[i].data}, i << 12);
            check($sformatf("ua_cyc%0d", i),  wlog[i].cyc, t_ref + 2 + 2 * i);
        end
        check("ua_done_count", dlog.size(), 32'd1);

        // Round-robin: sending ch5 leaves ptr = 6. Dirtying ch2 and ch7
        // together must then send ch7 before ch2.
        clear_logs();
        drive_cfg(3'd5, 12'h055);
        wait_idle("rr_first_timeout");
        @(posedge CLK); #1;
        CFG_WE = 1'b1; CFG_ADDR = 3'd2; CFG_DATA = 12'h022;
        @(posedge CLK); #1;
        CFG_ADDR = 3'd7; CFG_DATA = 12'h077;
        @(posedge CLK); #1;
        CFG_WE = 1'b0;
        wait_idle("rr_pair_timeout");
        check("rr_count", wlog.size(), 32'd3);
        check("rr_word0", {16'd0, wlog[0].data}, 32'h5055);
        check("rr_word1", {16'd0, wlog[1].data}, 32'h7077);
        check("rr_word2", {16'd0, wlog[2].data}, 32'h2022);

        // Back-pressure: FULL is held for 10 PUSH cycles, then released.
        clear_logs();
        @(posedge CLK); #1 FIFO_FULL = 1'b1;
        drive_cfg(3'd1, 12'h3C3);
        @(negedge CLK);
        @(negedge CLK);
        wr_hi = 0; din_bad = 0; lows = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (FIFO_WR_EN)          wr_hi++;
            if (FIFO_DIN != 16'h13C3) din_bad++;
            if (!BUSY)               lows++;
        end
        check("bp_wr_while_full", wr_hi, 32'd0);
        check("bp_din_unstable",  din_bad, 32'd0);
        check("bp_busy_gaps",     lows, 32'd0);
        @(posedge CLK); #1 FIFO_FULL = 1'b0;
        @(negedge CLK);
        check("bp_release_wr",  {31'd0, FIFO_WR_EN}, 32'd1);
        check("bp_release_din", {16'd0, FIFO_DIN}, 32'h13C3);
        wait_idle("bp_idle_timeout");
        check("bp_count", wlog.size(), 32'd1);
        check("bp_cycle", wlog[0].cyc, t_ref + 12);

        // Overwrite race: ch3 is rewritten in the ARB cycle that latches it.
        clear_logs();
        @(posedge CLK); #1;
        CFG_WE = 1'b1; CFG_ADDR = 3'd3; CFG_DATA = 12'h111;
        @(posedge CLK); #1;
        CFG_WE = 1'b0;
        t_ref = cyc_cnt;
        @(posedge CLK); #1;
        CFG_WE = 1'b1; CFG_ADDR = 3'd3; CFG_DATA = 12'h222;
        @(posedge CLK); #1;
        CFG_WE = 1'b0;
        wait_idle("race_idle_timeout");
        check("race_count", wlog.size(), 32'd2);
        check("race_word0", {16'd0, wlog[0].data}, 32'h3111);
        check("race_word1", {16'd0, wlog[1].data}, 32'h3222);
        check("race_cyc0",  wlog[0].cyc, t_ref + 2);
        check("race_cyc1",  wlog[1].cyc, t_ref + 4);
        check("race_done_count", dlog.size(), 32'd1);

        // Reset during the 4th push of an UPDATE_ALL batch.
        do_reset();
        clear_logs();
        pulse_update();
        repeat (8) @(posedge CLK);
        #1 RESET = 1'b1;
        @(negedge CLK);
        check("mr_4th_wr",  {31'd0, FIFO_WR_EN}, 32'd1);
        check("mr_4th_din", {16'd0, FIFO_DIN}, 32'h3000);
        @(posedge CLK); #1 RESET = 1'b0;
        @(negedge CLK);
        check("mr_din",   {16'd0, FIFO_DIN}, 32'h0);
        check("mr_wr_en", {31'd0, FIFO_WR_EN}, 32'd0);
        check("mr_busy",  {31'd0, BUSY}, 32'd0);
        check("mr_done",  {31'd0, DONE}, 32'd0);
        repeat (10) @(negedge CLK);
        check("mr_count", wlog.size(), 32'd4);
        clear_logs();
        drive_cfg(3'd0, 12'h001);
        wait_idle("mr_idle_timeout");
        check("mr_after_count", wlog.size(), 32'd1);
        check("mr_after_word",  {16'd0, wlog[0].data}, 32'h0001);

        check("wr_en_while_full", full_viol, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dac_update_sequencer.md
# dac_update_sequencer

Sequencer that feeds the `fifo2shiftreg` DAC serializer.
- Holds a shadow value per DAC channel and tracks which channels changed.
- Pushes one 16-bit command word per changed channel into the serializer FIFO, in round-robin order.
- Observes FIFO back-pressure.
- Sits between the slow-control register bank and `fifo2shiftreg`; the FIFO write clock is tied to `CLK`.

## Interface
Parameters:
- `NCH`, 8: number of DAC channels (power of 2, 2..16).
- `CH_BITS`, 3: log2(`NCH`).
- `VAL_BITS`, 12: DAC code width; `CH_BITS`+`VAL_BITS` ≤ 15.

Ports:
- `CLK` in 1: system clock; also drives the serializer FIFO write port.
- `RESET` in 1: synchronous, active-high reset.
- `CFG_WE` in 1: write strobe for one channel's shadow value.
- `CFG_ADDR` in `CH_BITS`: channel index for `CFG_WE`.
- `CFG_DATA` in `VAL_BITS`: new DAC code.
- `UPDATE_ALL` in 1: one-cycle pulse that marks every channel dirty.
- `FIFO_FULL` in 1: connects to `fifo2shiftreg` FULL.
- `FIFO_DIN` out 16: connects to `fifo2shiftreg` DIN.
- `FIFO_WR_EN` out 1: connects to `fifo2shiftreg` WR_EN (level enable, one word per high cycle).
- `BUSY` out 1: high whenever the FSM is not IDLE.
- `DONE` out 1: one-cycle pulse when the dirty set drains.

## Operation
- **Storage.**
  - `val[NCH]` holds the shadow codes.
  - `dirty[NCH]` holds one flag per channel.
  - `ptr` is the round-robin start index.
- **Command word.** `{1'b0, ch zero-extended to 15-VAL_BITS bits, val[ch]}`. For the defaults: `{1'b0, ch[2:0], val[11:0]}`.
- **`CFG_WE`.** Writes `val[CFG_ADDR]` and sets `dirty[CFG_ADDR]`.
- **`UPDATE_ALL`.** Sets all dirty bits. It may coincide with `CFG_WE`; both take effect.
- **FSM states:** IDLE, ARB, PUSH.
  - **IDLE** → ARB when any dirty bit is set (registered value).
  - **ARB.** Searches for the first set dirty bit starting at `ptr` and wrapping modulo `NCH`.
    - If one is found: latch the command word into `word_q`, record `ch_q`, clear `dirty[ch_q]`, go to PUSH.
    - If none is found: go to IDLE and pulse `DONE` (`LDAC_EN` variant: see Configuration).
  - **PUSH.** `FIFO_WR_EN = ~FIFO_FULL`, combinational; `FIFO_DIN = word_q`.
    - If `FIFO_FULL` is high: stay in PUSH.
    - If `FIFO_FULL` is low: the word is written this cycle; set `ptr = ch_q+1` (wrapping) and go to ARB.
- **Simultaneous clear/set.** If `CFG_WE` targets `ch_q` in the same cycle that ARB clears it, the set wins. The channel is re-sent later with its new value; the word already latched keeps the old value.
- **Reset (including mid-operation).**
  - `val`, `dirty`, `ptr`, `word_q` go to 0 and the state goes to IDLE.
  - A word already written to the FIFO is not recalled.

## Timing
- **Output reset values:** `FIFO_DIN`=0, `FIFO_WR_EN`=0, `BUSY`=0, `DONE`=0.
- **Latency.** With `CFG_WE` sampled at edge n while IDLE and FIFO not full:
  - dirty is set after edge n;
  - ARB occupies cycle n+1;
  - PUSH with `FIFO_WR_EN`=1 occupies cycle n+2.
- **Throughput:** one word per 2 cycles (ARB+PUSH) while not full.
- **`DONE` timing.** `DONE` is a registered pulse, high in the cycle after the empty-ARB cycle, together with the first IDLE cycle.
- **`BUSY` timing.** `BUSY` is registered from the state: it is high in ARB and PUSH.
- **`FIFO_FULL`.** Sampled in the PUSH cycle itself. The block never asserts `FIFO_WR_EN` while `FIFO_FULL` is high.
- **`FIFO_DIN` stability.** `FIFO_DIN` is stable throughout PUSH, including stall cycles.

## Configuration
- **Macro:** `DAC_SEQ_LDAC_EN`.
- **Defined.**
  - When ARB finds no dirty channel after at least one push in the current batch, the FSM enters an extra state LDAC instead of IDLE.
  - LDAC pushes the word 16'h8000 (software load-DAC) with the same FULL handshake, then goes to IDLE.
  - `DONE` pulses after the LDAC word is accepted.
- **Not defined.** No LDAC state; batches end with no trailing word.

## Test plan
- **Single write.** After reset, `CFG_WE` with ch=5, data=12'hABC.
  - `FIFO_WR_EN` is high for exactly one cycle, 2 cycles later, with `FIFO_DIN`=16'h5ABC.
  - `DONE` pulses once.
  - With `DAC_SEQ_LDAC_EN`, 16'h8000 follows.
- **`UPDATE_ALL` after reset.** Eight words 16'h0000, 16'h1000 … 16'h7000, in channel order, spaced 2 cycles apart; `BUSY` stays high throughout.
- **Round-robin.** Set `ptr`=6 by pushing ch5, then dirty ch2 and ch7 together. Order is ch7, then ch2.
- **Back-pressure.** Hold `FIFO_FULL`=1 for 10 cycles while in PUSH.
  - `FIFO_WR_EN` stays 0 and `FIFO_DIN` stays constant.
  - Exactly one write occurs on release.
- **Overwrite race.** `CFG_WE` ch3=12'h111; then, in the ARB cycle that latches ch3, `CFG_WE` ch3=12'h222. Words 16'h3111 then 16'h3222 are written.
- **Reset mid-batch.** Assert `RESET` during the 4th push of an `UPDATE_ALL` batch.
  - No further writes occur; all outputs are 0 the next cycle.
  - A subsequent `CFG_WE` ch0=12'h001 yields 16'h0001 only.
